// File: rtl/if_id_pkg.sv
// Shared IF/ID types and constants for the 5-stage core.
// Bubble encoding and default payload layout live here.
package if_id_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned ILEN_DEF = 32;

    localparam logic [ILEN_DEF-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
    } if_id_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register with a 1-entry skid slot.
// in_ready comes straight from a flop; empty main entry holds BUBBLE.
module pipe_skid_buf #(
    parameter int unsigned W = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_v;
    logic         skid_v;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    logic push;
    logic skid_pop;
    logic skid_hold;
    logic load_main;
    logic load_skid;
    logic drain;

    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_q;

    // Mutually exclusive actions so the decoder below is truly unique.
    always_comb begin
        push      = in_valid & ~skid_v;
        skid_pop  = skid_v & out_ready;
        skid_hold = skid_v & ~out_ready;
        load_main = push & (~main_v | out_ready);
        load_skid = push & main_v & ~out_ready;
        drain     = ~skid_v & ~push & main_v & out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= BUBBLE;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= BUBBLE;
            skid_q <= '0;
        end else begin
            unique case (1'b1)
                skid_pop: begin
                    main_q <= skid_q;
                    skid_v <= 1'b0;
                end
                skid_hold: ;
                load_main: begin
                    main_q <= in_data;
                    main_v <= 1'b1;
                end
                load_skid: begin
                    skid_q <= in_data;
                    skid_v <= 1'b1;
                end
                drain: begin
                    main_q <= BUBBLE;
                    main_v <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID stage: skid-buffered instr+PC with flush and NOP bubbles.
// Define IFID_PERF_EN to add saturating stall/flush counters.
module if_id_pipe_reg
    import if_id_pkg::*;
#(
    parameter int unsigned XLEN = if_id_pkg::XLEN_DEF,
    parameter int unsigned ILEN = if_id_pkg::ILEN_DEF,
    parameter logic [ILEN-1:0] NOP_INSTR = if_id_pkg::NOP_INSTR,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
`ifdef IFID_PERF_EN
    output logic [XLEN-1:0] out_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`else
    output logic [XLEN-1:0] out_pc
`endif
);

    // Same layout as if_id_payload_t, sized by this instance.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } payload_t;

    localparam payload_t BUBBLE = '{instr: NOP_INSTR, pc: '0};

    payload_t in_pl;
    payload_t out_pl;

    assign in_pl     = '{instr: in_instr, pc: in_pc};
    assign out_instr = out_pl.instr;
    assign out_pc    = out_pl.pc;

    pipe_skid_buf #(
        .W      ($bits(payload_t)),
        .BUBBLE (BUBBLE)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

`ifdef IFID_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: stream, stall, flush, drain.
// Perf counter checks run only when IFID_PERF_EN is defined.
module tb_if_id_pipe_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
`ifdef IFID_PERF_EN
    logic [1:0]  stall_cnt;
    logic [1:0]  flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

`ifdef IFID_PERF_EN
    if_id_pipe_reg #(.CNT_W(2)) dut (
`else
    if_id_pipe_reg dut (
`endif
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
`ifdef IFID_PERF_EN
        .out_pc    (out_pc),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`else
        .out_pc    (out_pc)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] ins);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_pc    = '0;
        in_instr = '0;
    endtask

    task automatic expect_bubble(input string tag);
        check({tag, "_v"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_i"}, {32'd0, out_instr}, {32'd0, NOP});
        check({tag, "_pc"}, out_pc, 64'd0);
    endtask

    task automatic expect_out(input string tag, input logic [63:0] pc,
                              input logic [31:0] ins);
        check({tag, "_v"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_i"}, {32'd0, out_instr}, {32'd0, ins});
        check({tag, "_pc"}, out_pc, pc);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();

        // Reset for two cycles
        tick();
        expect_bubble("rst0");
        tick();
        expect_bubble("rst1");
        check("rst_rdy", {63'd0, in_ready}, 64'd1);
        reset = 1'b0;
        tick();
        expect_bubble("post_rst");
        check("post_rdy", {63'd0, in_ready}, 64'd1);

        // Streaming, out_ready high
        out_ready = 1'b1;
        push(64'h1000, 32'hAAAA_0001);
        tick();
        expect_out("s0", 64'h1000, 32'hAAAA_0001);
        check("s0_rdy", {63'd0, in_ready}, 64'd1);
        push(64'h1004, 32'hAAAA_0002);
        tick();
        expect_out("s1", 64'h1004, 32'hAAAA_0002);
        check("s1_rdy", {63'd0, in_ready}, 64'd1);
        push(64'h1008, 32'hAAAA_0003);
        tick();
        expect_out("s2", 64'h1008, 32'hAAAA_0003);
        check("s2_rdy", {63'd0, in_ready}, 64'd1);
        idle();
        tick();
        expect_bubble("s_end");

        // Stall with skid fill
        out_ready = 1'b0;
        push(64'h2000, 32'hBBBB_0000);
        tick();
        expect_out("st0", 64'h2000, 32'hBBBB_0000);
        push(64'h2004, 32'hBBBB_0004);
        tick();
        idle();
        expect_out("st1", 64'h2000, 32'hBBBB_0000);
        check("st1_rdy", {63'd0, in_ready}, 64'd0);
        tick();
        expect_out("st2", 64'h2000, 32'hBBBB_0000);
        check("st2_rdy", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();
        expect_out("st3", 64'h2004, 32'hBBBB_0004);
        check("st3_rdy", {63'd0, in_ready}, 64'd1);
        tick();
        expect_bubble("st4");

        // Flush with skid full and fetch presenting 0x3000
        out_ready = 1'b0;
        push(64'h2100, 32'hCCCC_0000);
        tick();
        push(64'h2104, 32'hCCCC_0004);
        tick();
        check("fl_pre_rdy", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        push(64'h3000, 32'hDDDD_3000);
        tick();
        flush = 1'b0;
        idle();
        expect_bubble("fl0");
        check("fl0_rdy", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        tick();
        expect_bubble("fl1");
        tick();
        expect_bubble("fl2");

        // Flush on empty stage discards a real push
        flush = 1'b1;
        push(64'h3100, 32'hDDDD_3100);
        tick();
        flush = 1'b0;
        idle();
        expect_bubble("fl_push");
        tick();
        expect_bubble("fl_push2");

        // Single-entry drain
        push(64'h4000, 32'hEEEE_4000);
        tick();
        idle();
        expect_out("dr0", 64'h4000, 32'hEEEE_4000);
        tick();
        expect_bubble("dr1");

        // Reset mid-operation
        out_ready = 1'b0;
        push(64'h5000, 32'hFFFF_5000);
        tick();
        push(64'h5004, 32'hFFFF_5004);
        tick();
        idle();
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        expect_bubble("mid_rst");
        check("mid_rst_rdy", {63'd0, in_ready}, 64'd1);

`ifdef IFID_PERF_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("pc_stall0", {62'd0, stall_cnt}, 64'd0);
        check("pc_flush0", {62'd0, flush_cnt}, 64'd0);
        out_ready = 1'b0;
        push(64'h6000, 32'h1111_6000);
        tick();
        idle();
        for (int i = 0; i < 5; i++) tick();
        check("pc_stall_sat", {62'd0, stall_cnt}, 64'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("pc_flush1", {62'd0, flush_cnt}, 64'd1);
        check("pc_stall_hold", {62'd0, stall_cnt}, 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("pc_stall_rst", {62'd0, stall_cnt}, 64'd0);
        check("pc_flush_rst", {62'd0, flush_cnt}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
